// File: rtl/ap_mon_pkg.sv
// Shared types, read-select codes and the saturating increment used by the
// ap_ctrl performance monitor.
package ap_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_CONT = 2'd2
    } ch_state_e;

    localparam logic [2:0] RD_SEL_TXN_CNT   = 3'd0;
    localparam logic [2:0] RD_SEL_LAT_LAST  = 3'd1;
    localparam logic [2:0] RD_SEL_LAT_MIN   = 3'd2;
    localparam logic [2:0] RD_SEL_LAT_MAX   = 3'd3;
    localparam logic [2:0] RD_SEL_STALL_CNT = 3'd4;
    localparam logic [2:0] RD_SEL_II_LAST   = 3'd5;
    localparam logic [2:0] RD_SEL_STATE     = 3'd6;
    localparam logic [2:0] RD_SEL_RSVD      = 3'd7;

    // Widest counter supported; callers zero-extend into this width.
    localparam int SAT_W = 64;

    // Increment that holds at lim instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/ap_chan_monitor.sv
// One ap_ctrl channel: handshake FSM, latency timer and per-channel statistics.
//
// state        | meaning
// ST_IDLE      | nothing in flight; accepts ap_start unless finish is high
// ST_RUN       | transaction in flight; lat_cnt counts cycles since start
// ST_WAIT_CONT | ap_done seen with ap_continue low; latency frozen, stalls counted
module ap_chan_monitor
    import ap_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    input  logic             clear,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] lat_last,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] ii_last
);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    ch_state_e        state_q;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_run;
    logic [CNT_W-1:0] rec_lat;
    logic [CNT_W-1:0] ii_cnt;
    logic             ready_seen;
    logic             start_ok;
    logic             rec;
    logic             stall_inc;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(SAT_W'(v), SAT_W'(ALL_ONES)));
    endfunction

    assign start_ok = ap_start && !finish;
    // Latency if the transaction ends this cycle (this cycle included).
    assign lat_run  = inc(lat_cnt);
    assign state    = state_q;

    // Decide whether this cycle closes a transaction and whether it is a continue stall.
    always_comb begin
        rec       = 1'b0;
        rec_lat   = lat_run;
        stall_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok && ap_done) begin
                    rec       = ap_continue;
                    stall_inc = !ap_continue;
                    rec_lat   = ONE;
                end
            end
            ST_RUN: begin
                rec       = ap_done && ap_continue;
                stall_inc = ap_done && !ap_continue;
            end
            ST_WAIT_CONT: begin
                rec       = ap_continue;
                stall_inc = !ap_continue;
                rec_lat   = lat_cnt;
            end
            default: ;
        endcase
    end

    // Channel FSM, latency/II timers and statistics; clear only touches the statistics.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lat_cnt    <= '0;
            ii_cnt     <= '0;
            ready_seen <= 1'b0;
            txn_cnt    <= '0;
            lat_last   <= '0;
            lat_min    <= ALL_ONES;
            lat_max    <= '0;
            stall_cnt  <= '0;
            ii_last    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        lat_cnt <= ONE;
                        if (!ap_done) begin
                            state_q <= ST_RUN;
                        end else if (!ap_continue) begin
                            state_q <= ST_WAIT_CONT;
                        end
                    end
                end
                ST_RUN: begin
                    if (ap_done && ap_continue) begin
                        if (start_ok) begin
                            lat_cnt <= ONE;
                        end else begin
                            lat_cnt <= lat_run;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_run;
                        if (ap_done) begin
                            state_q <= ST_WAIT_CONT;
                        end
                    end
                end
                ST_WAIT_CONT: begin
                    if (ap_continue) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (clear) begin
                txn_cnt   <= '0;
                lat_last  <= '0;
                lat_min   <= ALL_ONES;
                lat_max   <= '0;
                stall_cnt <= '0;
                ii_last   <= '0;
            end else begin
                if (rec) begin
                    txn_cnt  <= inc(txn_cnt);
                    lat_last <= rec_lat;
                    if (rec_lat < lat_min) lat_min <= rec_lat;
                    if (rec_lat > lat_max) lat_max <= rec_lat;
                end
                if (stall_inc) begin
                    stall_cnt <= inc(stall_cnt);
                end
                if (ap_ready && ready_seen) begin
                    ii_last <= ii_cnt;
                end
            end

            if (ap_ready) begin
                ii_cnt     <= ONE;
                ready_seen <= 1'b1;
            end else begin
                ii_cnt <= inc(ii_cnt);
            end
        end
    end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl handshake monitor: one ap_chan_monitor per channel,
// an all-idle flag and a registered statistics read port.
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              all_idle
);
    logic [1:0]        ch_state  [NUM_CH];
    logic [CNT_W-1:0]  txn_cnt   [NUM_CH];
    logic [CNT_W-1:0]  lat_last  [NUM_CH];
    logic [CNT_W-1:0]  lat_min   [NUM_CH];
    logic [CNT_W-1:0]  lat_max   [NUM_CH];
    logic [CNT_W-1:0]  stall_cnt [NUM_CH];
    logic [CNT_W-1:0]  ii_last   [NUM_CH];
    logic [NUM_CH-1:0] ch_idle;
    logic [CNT_W-1:0]  sel_data;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ap_chan_monitor #(.CNT_W(CNT_W)) u_ch (
            .clock       (clock),
            .reset       (reset),
            .ap_start    (ap_start[i]),
            .ap_ready    (ap_ready[i]),
            .ap_done     (ap_done[i]),
            .ap_continue (ap_continue[i]),
            .finish      (finish),
            .clear       (clear),
            .state       (ch_state[i]),
            .txn_cnt     (txn_cnt[i]),
            .lat_last    (lat_last[i]),
            .lat_min     (lat_min[i]),
            .lat_max     (lat_max[i]),
            .stall_cnt   (stall_cnt[i]),
            .ii_last     (ii_last[i])
        );
        assign ch_idle[i] = (ch_state[i] == ST_IDLE);
    end

    assign all_idle = &ch_idle;

    // Pick the requested statistic; channels beyond NUM_CH and the reserved select read 0.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_sel)
                    RD_SEL_TXN_CNT:   sel_data = txn_cnt[i];
                    RD_SEL_LAT_LAST:  sel_data = lat_last[i];
                    RD_SEL_LAT_MIN:   sel_data = lat_min[i];
                    RD_SEL_LAT_MAX:   sel_data = lat_max[i];
                    RD_SEL_STALL_CNT: sel_data = stall_cnt[i];
                    RD_SEL_II_LAST:   sel_data = ii_last[i];
                    RD_SEL_STATE:     sel_data = CNT_W'(ch_state[i]);
                    RD_SEL_RSVD:      sel_data = '0;
                    default:          sel_data = '0;
                endcase
            end
        end
    end

    // One-cycle registered read; rd_data holds between reads.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: directed sequences checked from a vector table,
// then randomized traffic checked against a timestamp-based transaction model.
module tb_ap_ctrl_perf_monitor;
    localparam int NCH  = 4;
    localparam int CW   = 32;
    localparam int S_NCH = 3;
    localparam int S_CW  = 4;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset;

    logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic           finish, clear, rd_en;
    logic [1:0]     rd_ch;
    logic [2:0]     rd_sel;
    logic [CW-1:0]  rd_data;
    logic           rd_valid, all_idle;

    logic [S_NCH-1:0] s_start, s_ready, s_done, s_cont;
    logic             s_finish, s_clear, s_rd_en;
    logic [1:0]       s_rd_ch;
    logic [2:0]       s_rd_sel;
    logic [S_CW-1:0]  s_rd_data;
    logic             s_rd_valid, s_all_idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .clear(clear),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .rd_valid(rd_valid), .all_idle(all_idle)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(S_NCH), .CNT_W(S_CW)) dut_s (
        .clock(clock), .reset(reset),
        .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done), .ap_continue(s_cont),
        .finish(s_finish), .clear(s_clear),
        .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .all_idle(s_all_idle)
    );

    // ---------------- reference model (main instance) ----------------
    // Transactions tracked by start timestamps; latency = done cycle - start cycle + 1.
    bit     m_busy [NCH];
    bit     m_wait [NCH];
    bit     m_seen [NCH];
    longint m_start[NCH], m_pend[NCH], m_prev_rdy[NCH];
    longint m_txn[NCH], m_last[NCH], m_min[NCH], m_max[NCH], m_stall[NCH], m_ii[NCH];
    longint cyc;

    function automatic longint sat(input longint v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_busy[c] = 0; m_wait[c] = 0; m_seen[c] = 0;
            m_start[c] = 0; m_pend[c] = 0; m_prev_rdy[c] = 0;
            m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
            m_stall[c] = 0; m_ii[c] = 0;
        end
        cyc = 0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit     rec;
            bit     stl;
            longint lat;
            rec = 0; stl = 0; lat = 0;
            if (m_wait[c]) begin
                if (ap_continue[c]) begin rec = 1; lat = m_pend[c]; m_wait[c] = 0; end
                else stl = 1;
            end else if (m_busy[c]) begin
                if (ap_done[c]) begin
                    lat = cyc - m_start[c] + 1;
                    if (ap_continue[c]) begin
                        rec = 1;
                        if (ap_start[c] && !finish) m_start[c] = cyc;
                        else m_busy[c] = 0;
                    end else begin
                        m_busy[c] = 0; m_wait[c] = 1; m_pend[c] = sat(lat); stl = 1;
                    end
                end
            end else if (ap_start[c] && !finish) begin
                if (!ap_done[c]) begin m_busy[c] = 1; m_start[c] = cyc; end
                else if (ap_continue[c]) begin rec = 1; lat = 1; end
                else begin m_wait[c] = 1; m_pend[c] = 1; stl = 1; end
            end
            lat = sat(lat);
            if (clear) begin
                m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
                m_stall[c] = 0; m_ii[c] = 0;
            end else begin
                if (rec) begin
                    m_txn[c]  = sat(m_txn[c] + 1);
                    m_last[c] = lat;
                    if (lat < m_min[c]) m_min[c] = lat;
                    if (lat > m_max[c]) m_max[c] = lat;
                end
                if (stl) m_stall[c] = sat(m_stall[c] + 1);
                if (ap_ready[c] && m_seen[c]) m_ii[c] = sat(cyc - m_prev_rdy[c]);
            end
            if (ap_ready[c]) begin m_seen[c] = 1; m_prev_rdy[c] = cyc; end
        end
        cyc++;
    endtask

    function automatic logic [31:0] exp_read(input int ch, input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            0: v = 32'(m_txn[ch]);
            1: v = 32'(m_last[ch]);
            2: v = 32'(m_min[ch]);
            3: v = 32'(m_max[ch]);
            4: v = 32'(m_stall[ch]);
            5: v = 32'(m_ii[ch]);
            6: v = m_wait[ch] ? 32'd2 : (m_busy[ch] ? 32'd1 : 32'd0);
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic model_all_idle();
        logic r;
        r = 1'b1;
        for (int c = 0; c < NCH; c++) if (m_busy[c] || m_wait[c]) r = 1'b0;
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(input int ch, input int sel, input logic [31:0] exp, input string name);
        rd_en = 1'b1; rd_ch = 2'(ch); rd_sel = 3'(sel);
        tick();
        rd_en = 1'b0;
        check({name, "_valid"}, 64'(rd_valid), 64'd1);
        check(name, 64'(rd_data), 64'(exp));
    endtask

    task automatic s_read(input int ch, input int sel, input logic [3:0] exp, input string name);
        s_rd_en = 1'b1; s_rd_ch = 2'(ch); s_rd_sel = 3'(sel);
        tick();
        s_rd_en = 1'b0;
        check({name, "_valid"}, 64'(s_rd_valid), 64'd1);
        check(name, 64'(s_rd_data), 64'(exp));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          grp;
        int          ch;
        int          sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int g, input int ch, input int sel, input logic [31:0] exp, input string name);
        vec_t v;
        v.grp = g; v.ch = ch; v.sel = sel; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic run_grp(input int g);
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].grp == g) do_read(vecs[i].ch, vecs[i].sel, vecs[i].exp, vecs[i].name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete within %0d time units", 5000000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_rd;
        bit          prev_rd;

        // group 0: post-reset state of every channel/select
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 8; s++)
                add(0, c, s, (s == 2) ? 32'hFFFF_FFFF : 32'd0, $sformatf("reset_ch%0d_sel%0d", c, s));
        // group 1: single transaction ch0, latency 10
        add(1, 0, 0, 32'd1,  "t2_txn");
        add(1, 0, 1, 32'd10, "t2_lat_last");
        add(1, 0, 2, 32'd10, "t2_lat_min");
        add(1, 0, 3, 32'd10, "t2_lat_max");
        add(1, 0, 4, 32'd0,  "t2_stall");
        add(1, 0, 6, 32'd0,  "t2_state");
        // group 2: continue stall ch1
        add(2, 1, 0, 32'd1,  "t3_txn");
        add(2, 1, 1, 32'd4,  "t3_lat_last");
        add(2, 1, 4, 32'd4,  "t3_stall");
        add(2, 1, 6, 32'd0,  "t3_state");
        // group 3: back-to-back ch2
        add(3, 2, 0, 32'd3,  "t4_txn");
        add(3, 2, 1, 32'd5,  "t4_lat_last");
        add(3, 2, 2, 32'd5,  "t4_lat_min");
        add(3, 2, 3, 32'd5,  "t4_lat_max");
        add(3, 2, 5, 32'd5,  "t4_ii_last");
        add(3, 2, 4, 32'd0,  "t4_stall");
        // group 4: start and done in the same cycle on ch1
        add(4, 1, 0, 32'd2,  "same_txn");
        add(4, 1, 1, 32'd1,  "same_lat_last");
        add(4, 1, 2, 32'd1,  "same_lat_min");
        add(4, 1, 3, 32'd4,  "same_lat_max");
        // group 5: finish on ch3
        add(5, 3, 0, 32'd1,  "t5_txn");
        add(5, 3, 1, 32'd6,  "t5_lat_last");
        add(5, 3, 6, 32'd0,  "t5_state");
        // group 6: after clear
        add(6, 0, 0, 32'd0,          "clr_txn_ch0");
        add(6, 0, 2, 32'hFFFF_FFFF,  "clr_lat_min_ch0");
        add(6, 1, 1, 32'd0,          "clr_lat_last_ch1");
        add(6, 1, 4, 32'd0,          "clr_stall_ch1");
        add(6, 2, 5, 32'd0,          "clr_ii_ch2");
        add(6, 3, 3, 32'd0,          "clr_lat_max_ch3");
        // group 7: record coinciding with clear is dropped
        add(7, 0, 0, 32'd0,          "clrrec_txn");
        add(7, 0, 1, 32'd0,          "clrrec_lat_last");
        add(7, 0, 2, 32'hFFFF_FFFF,  "clrrec_lat_min");

        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        finish = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
        s_start = '0; s_ready = '0; s_done = '0; s_cont = '1;
        s_finish = 1'b0; s_clear = 1'b0; s_rd_en = 1'b0; s_rd_ch = '0; s_rd_sel = '0;
        prev_rd = 0;
        exp_rd = '0;
        model_reset();

        // T1: reset held low for 3 cycles
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_all_idle", 64'(all_idle), 64'd1);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_s_all_idle", 64'(s_all_idle), 64'd1);
        check("reset_s_rd_data", 64'(s_rd_data), 64'd0);
        reset = 1'b1;
        run_grp(0);

        // T2: ch0 start at t0, done at t0+9
        ap_start[0] = 1'b1; tick();
        ap_start[0] = 1'b0;
        check("t2_busy", 64'(all_idle), 64'd0);
        tick_n(8);
        ap_done[0] = 1'b1; tick();
        ap_done[0] = 1'b0;
        run_grp(1);

        // T3: ch1 done with continue low for 4 cycles
        ap_start[1] = 1'b1; tick();
        ap_start[1] = 1'b0; tick_n(2);
        ap_done[1] = 1'b1; ap_continue[1] = 1'b0; tick();
        ap_done[1] = 1'b0; tick_n(2);
        do_read(1, 6, 32'd2, "t3_state_wait");
        ap_continue[1] = 1'b1; tick();
        run_grp(2);

        // T4: ch2 start held, done every 4 cycles after the first (latency 5), ready every 5
        for (int k = 0; k <= 12; k++) begin
            ap_start[2] = (k < 12);
            ap_ready[2] = (k % 5 == 0);
            ap_done[2]  = (k == 4 || k == 8 || k == 12);
            tick();
        end
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
        run_grp(3);

        // start and done together on ch1 -> latency 1
        ap_start[1] = 1'b1; ap_done[1] = 1'b1; tick();
        ap_start[1] = 1'b0; ap_done[1] = 1'b0;
        run_grp(4);

        // T5: finish raised mid-RUN on ch3
        ap_start[3] = 1'b1; tick();
        ap_start[3] = 1'b0; tick_n(2);
        finish = 1'b1; tick();
        check("t5_run_not_idle", 64'(all_idle), 64'd0);
        tick();
        ap_done[3] = 1'b1; tick();
        ap_done[3] = 1'b0; ap_start[3] = 1'b1; tick_n(3);
        check("t5_all_idle", 64'(all_idle), 64'd1);
        run_grp(5);
        ap_start[3] = 1'b0; finish = 1'b0;

        // clear pulse
        clear = 1'b1; tick();
        clear = 1'b0;
        run_grp(6);

        // record coinciding with clear
        ap_start[0] = 1'b1; tick();
        ap_start[0] = 1'b0; ap_done[0] = 1'b1; clear = 1'b1; tick();
        ap_done[0] = 1'b0; clear = 1'b0;
        run_grp(7);

        // T6: CNT_W=4 instance, 20-cycle txn saturates, out-of-range channel reads 0
        s_start[0] = 1'b1; tick();
        s_start[0] = 1'b0; tick_n(18);
        s_done[0] = 1'b1; tick();
        s_done[0] = 1'b0;
        s_start[1] = 1'b1; tick();
        s_start[1] = 1'b0; s_done[1] = 1'b1; s_cont[1] = 1'b0; tick();
        s_done[1] = 1'b0; tick_n(19);
        s_cont[1] = 1'b1; tick();
        s_read(0, 0, 4'd1,  "t6_txn");
        s_read(0, 1, 4'hF,  "t6_lat_last_sat");
        s_read(0, 3, 4'hF,  "t6_lat_max_sat");
        s_read(1, 4, 4'hF,  "t6_stall_sat");
        s_read(1, 1, 4'd2,  "t6_ch1_lat");
        for (int s = 0; s < 8; s++) s_read(S_NCH, s, 4'd0, $sformatf("t6_bad_ch_sel%0d", s));
        check("t6_s_all_idle", 64'(s_all_idle), 64'd1);

        tick();

        // randomized traffic vs reference model
        for (int k = 0; k < 3000; k++) begin
            if (prev_rd) check("rnd_rd_data", 64'(rd_data), 64'(exp_rd));
            check("rnd_rd_valid", 64'(rd_valid), 64'(prev_rd));
            check("rnd_all_idle", 64'(all_idle), 64'(model_all_idle()));
            finish = ((k / 250) % 4 == 3);
            for (int c = 0; c < NCH; c++) begin
                ap_start[c]    = ($urandom_range(0, 99) < 40);
                ap_done[c]     = ($urandom_range(0, 99) < 30);
                ap_continue[c] = ($urandom_range(0, 99) < 70);
                ap_ready[c]    = ($urandom_range(0, 99) < 25);
            end
            clear  = ($urandom_range(0, 99) < 2);
            rd_en  = 1'($urandom_range(0, 1));
            rd_ch  = 2'($urandom_range(0, 3));
            rd_sel = 3'($urandom_range(0, 7));
            exp_rd = exp_read(int'(rd_ch), int'(rd_sel));
            prev_rd = rd_en;
            tick();
        end
        if (prev_rd) check("rnd_rd_data_last", 64'(rd_data), 64'(exp_rd));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
